// File: rtl/baud_rate_controller_if.sv
// Host/UART-facing signal bundle of the baud tick scheduler.
// slave = controller side, master = host config regs plus UART TX/RX side.
interface baud_rate_controller_if #(
    parameter int unsigned DIV_W = 16
);
    logic             enable;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             tx_busy;
    logic             rx_busy;
    logic             hold_o;
    logic             tick_16x;
    logic             tick_1x;
    logic [DIV_W-1:0] cur_div;

    modport master (
        output enable, cfg_valid, cfg_div, tx_busy, rx_busy,
        input  cfg_ready, hold_o, tick_16x, tick_1x, cur_div
    );

    modport slave (
        input  enable, cfg_valid, cfg_div, tx_busy, rx_busy,
        output cfg_ready, hold_o, tick_16x, tick_1x, cur_div
    );
endinterface

// File: rtl/baud_rate_controller.sv
// Runtime-programmable baud tick scheduler: prescaler producing tick_16x/tick_1x enables,
// with a drain-then-reload sequence so divisor changes never corrupt an in-flight frame.
module baud_rate_controller #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 324,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic                  clk_in,
    input  logic                  rst,
    baud_rate_controller_if.slave bus
);
    localparam int unsigned SUB_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pending_q, pending_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             hold_q, hold_d;
    logic             tick16_q, tick16_d;
    logic             tick1_q, tick1_d;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            sub_q       <= '0;
            cur_div_q   <= DIV_W'(DEFAULT_DIV);
            pending_q   <= '0;
            cfg_ready_q <= 1'b1;
            hold_q      <= 1'b0;
            tick16_q    <= 1'b0;
            tick1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sub_q       <= sub_d;
            cur_div_q   <= cur_div_d;
            pending_q   <= pending_d;
            cfg_ready_q <= cfg_ready_d;
            hold_q      <= hold_d;
            tick16_q    <= tick16_d;
            tick1_q     <= tick1_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sub_d       = sub_q;
        cur_div_d   = cur_div_q;
        pending_d   = pending_q;
        cfg_ready_d = cfg_ready_q;
        hold_d      = hold_q;
        tick16_d    = 1'b0;
        tick1_d     = 1'b0;

        // Prescaler keeps the old rate through DRAIN so in-flight frames complete.
        if (state_q != LOAD && bus.enable) begin
            if (cnt_q == cur_div_q) begin
                cnt_d    = '0;
                tick16_d = 1'b1;
                if (sub_q == SUB_W'(OVERSAMPLE - 1)) begin
                    sub_d   = '0;
                    tick1_d = 1'b1;
                end else begin
                    sub_d = sub_q + SUB_W'(1);
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        case (state_q)
            RUN: begin
                if (bus.cfg_valid && cfg_ready_q) begin
                    pending_d   = (bus.cfg_div == '0) ? DIV_W'(1) : bus.cfg_div;
                    cfg_ready_d = 1'b0;
                    hold_d      = 1'b1;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.tx_busy && !bus.rx_busy) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Realign both counters to the new divisor; any tick due now is dropped.
                cur_div_d   = pending_q;
                cnt_d       = '0;
                sub_d       = '0;
                cfg_ready_d = 1'b1;
                hold_d      = 1'b0;
                state_d     = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.hold_o    = hold_q;
    assign bus.tick_16x  = tick16_q;
    assign bus.tick_1x   = tick1_q;
    assign bus.cur_div   = cur_div_q;
endmodule

// File: tb/tb_baud_rate_controller.sv
// Self-checking bench for baud_rate_controller: directed scenarios plus a randomized run
// against a behavioural model that predicts ticks from enabled-cycle counts since alignment.
module tb_baud_rate_controller;
    localparam int unsigned DIV_W       = 16;
    localparam int unsigned DEFAULT_DIV = 324;
    localparam int unsigned OVS         = 16;

    logic clk_in = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk_in = ~clk_in;

    baud_rate_controller_if #(.DIV_W(DIV_W)) bus ();

    baud_rate_controller #(
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(DEFAULT_DIV),
        .OVERSAMPLE (OVS)
    ) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .bus   (bus)
    );

    // Reference model: mode 0 = accepting, 1 = draining, 2 = reloading.
    int              m_mode;
    longint unsigned m_e;
    int unsigned     m_div;
    int unsigned     m_pend;
    logic            m_t16, m_t1, m_ready, m_hold;
    longint unsigned m_per, m_ne;

    always_comb begin
        m_per = 64'(m_div) + 64'd1;
        m_ne  = bus.enable ? m_e + 64'd1 : m_e;
    end

    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            m_mode  <= 0;
            m_e     <= 64'd0;
            m_div   <= DEFAULT_DIV;
            m_pend  <= 0;
            m_t16   <= 1'b0;
            m_t1    <= 1'b0;
            m_ready <= 1'b1;
            m_hold  <= 1'b0;
        end else if (m_mode == 2) begin
            m_div   <= m_pend;
            m_e     <= 64'd0;
            m_t16   <= 1'b0;
            m_t1    <= 1'b0;
            m_ready <= 1'b1;
            m_hold  <= 1'b0;
            m_mode  <= 0;
        end else begin
            m_e   <= m_ne;
            m_t16 <= bus.enable && ((m_ne % m_per) == 64'd0);
            m_t1  <= bus.enable && ((m_ne % m_per) == 64'd0) && (((m_ne / m_per) % 64'(OVS)) == 64'd0);
            if (m_mode == 0 && bus.cfg_valid) begin
                m_pend  <= (bus.cfg_div == '0) ? 32'd1 : 32'(bus.cfg_div);
                m_ready <= 1'b0;
                m_hold  <= 1'b1;
                m_mode  <= 1;
            end else if (m_mode == 1 && !bus.tx_busy && !bus.rx_busy) begin
                m_mode <= 2;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
        bus.tx_busy   = 1'b0;
        bus.rx_busy   = 1'b0;
        repeat (3) @(negedge clk_in);
        n_cmp++;
        if (bus.cur_div !== 16'd324 || bus.cfg_ready !== 1'b1 || bus.hold_o !== 1'b0 ||
            bus.tick_16x !== 1'b0 || bus.tick_1x !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: div=%0d rdy=%b hold=%b t16=%b t1=%b, want 324 1 0 0 0",
                     bus.cur_div, bus.cfg_ready, bus.hold_o, bus.tick_16x, bus.tick_1x);
        end
        rst = 1'b0;
    endtask

    task automatic test_default_rate();
        int last16 = 0;
        int n16 = 0;
        int n1 = 0;
        bus.enable = 1'b1;
        for (int c = 1; c <= 2 * 5200 + 10; c++) begin
            @(negedge clk_in);
            if (bus.tick_16x === 1'b1) begin
                n16++;
                n_cmp++;
                if (c !== last16 + 325) begin
                    n_bad++;
                    $display("FAIL default_tick16_period: tick at cycle %0d, want %0d", c, last16 + 325);
                end
                last16 = c;
            end
            if (bus.tick_1x === 1'b1) begin
                n1++;
                n_cmp++;
                if (bus.tick_16x !== 1'b1 || (c % 5200) != 0) begin
                    n_bad++;
                    $display("FAIL default_tick1x: at cycle %0d t16=%b, want multiple of 5200 with t16=1", c, bus.tick_16x);
                end
            end
        end
        n_cmp++;
        if (n16 != 32 || n1 != 2) begin
            n_bad++;
            $display("FAIL default_tick_counts: t16=%0d t1=%0d, want 32 2", n16, n1);
        end
    endtask

    task automatic test_reconfig(input logic [DIV_W-1:0] req, input int unsigned exp_div, input string name);
        int unsigned per = exp_div + 1;
        bus.tx_busy   = 1'b0;
        bus.rx_busy   = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = req;
        n_cmp++;
        if (bus.cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_ready_before: rdy=%b, want 1", name, bus.cfg_ready);
        end
        @(negedge clk_in);
        // A request presented while not ready must be ignored.
        bus.cfg_div = 16'd5;
        n_cmp++;
        if (bus.cfg_ready !== 1'b0 || bus.hold_o !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_drain: rdy=%b hold=%b, want 0 1", name, bus.cfg_ready, bus.hold_o);
        end
        @(negedge clk_in);
        n_cmp++;
        if (bus.cfg_ready !== 1'b0 || bus.cur_div !== 16'd324 && bus.cur_div === DIV_W'(exp_div)) begin
            n_bad++;
            $display("FAIL %s_load: rdy=%b div=%0d, want rdy 0 and old div", name, bus.cfg_ready, bus.cur_div);
        end
        @(negedge clk_in);
        bus.cfg_valid = 1'b0;
        n_cmp++;
        if (bus.cfg_ready !== 1'b1 || bus.hold_o !== 1'b0 || bus.cur_div !== DIV_W'(exp_div) ||
            bus.tick_16x !== 1'b0 || bus.tick_1x !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_applied: rdy=%b hold=%b div=%0d t16=%b t1=%b, want 1 0 %0d 0 0",
                     name, bus.cfg_ready, bus.hold_o, bus.cur_div, bus.tick_16x, bus.tick_1x, exp_div);
        end
        for (int c = 1; c <= int'(2 * per * OVS); c++) begin
            @(negedge clk_in);
            n_cmp++;
            if ({bus.tick_16x, bus.tick_1x} !== {(c % per) == 0, (c % (per * OVS)) == 0} ||
                bus.cur_div !== DIV_W'(exp_div)) begin
                n_bad++;
                $display("FAIL %s_ticks: cycle %0d t16=%b t1=%b div=%0d, want %b %b %0d", name, c,
                         bus.tick_16x, bus.tick_1x, bus.cur_div, (c % per) == 0, (c % (per * OVS)) == 0, exp_div);
            end
        end
    endtask

    task automatic test_drain_busy();
        bus.tx_busy = 1'b1;
        do_reset();
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 16'd10;
        for (int c = 1; c <= 1020; c++) begin
            @(negedge clk_in);
            bus.cfg_valid = 1'b0;
            n_cmp++;
            if (bus.tick_16x !== ((c % 325) == 0) || bus.hold_o !== 1'b1 ||
                bus.cfg_ready !== 1'b0 || bus.cur_div !== 16'd324) begin
                n_bad++;
                $display("FAIL drain_busy: cycle %0d t16=%b hold=%b rdy=%b div=%0d, want %b 1 0 324",
                         c, bus.tick_16x, bus.hold_o, bus.cfg_ready, bus.cur_div, (c % 325) == 0);
            end
            if (c == 1000) begin
                bus.tx_busy = 1'b0;
                bus.rx_busy = 1'b1;
            end
            if (c == 1020) bus.rx_busy = 1'b0;
        end
        @(negedge clk_in);
        n_cmp++;
        if (bus.cfg_ready !== 1'b0 || bus.cur_div !== 16'd324) begin
            n_bad++;
            $display("FAIL drain_load_cycle: rdy=%b div=%0d, want 0 324", bus.cfg_ready, bus.cur_div);
        end
        @(negedge clk_in);
        n_cmp++;
        if (bus.cfg_ready !== 1'b1 || bus.hold_o !== 1'b0 || bus.cur_div !== 16'd10) begin
            n_bad++;
            $display("FAIL drain_reloaded: rdy=%b hold=%b div=%0d, want 1 0 10", bus.cfg_ready, bus.hold_o, bus.cur_div);
        end
    endtask

    task automatic test_reset_in_drain();
        bus.tx_busy   = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 16'd7;
        @(negedge clk_in);
        bus.cfg_valid = 1'b0;
        repeat (5) @(negedge clk_in);
        n_cmp++;
        if (bus.hold_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_drain_pre: hold=%b, want 1", bus.hold_o);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.cur_div !== 16'd324 || bus.cfg_ready !== 1'b1 || bus.hold_o !== 1'b0 ||
            bus.tick_16x !== 1'b0 || bus.tick_1x !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_drain_async: div=%0d rdy=%b hold=%b t16=%b t1=%b, want 324 1 0 0 0",
                     bus.cur_div, bus.cfg_ready, bus.hold_o, bus.tick_16x, bus.tick_1x);
        end
        @(negedge clk_in);
        rst         = 1'b0;
        bus.tx_busy = 1'b0;
        for (int c = 1; c <= 330; c++) begin
            @(negedge clk_in);
            n_cmp++;
            if (bus.tick_16x !== (c == 325) || bus.cur_div !== 16'd324) begin
                n_bad++;
                $display("FAIL rst_drain_after: cycle %0d t16=%b div=%0d, want %b 324", c, bus.tick_16x, bus.cur_div, c == 325);
            end
        end
    endtask

    task automatic test_enable_freeze();
        do_reset();
        for (int c = 1; c <= 700; c++) begin
            @(negedge clk_in);
            n_cmp++;
            if (bus.tick_16x !== (c == 335 || c == 660)) begin
                n_bad++;
                $display("FAIL enable_freeze: cycle %0d t16=%b, want %b", c, bus.tick_16x, c == 335 || c == 660);
            end
            if (c == 100) bus.enable = 1'b0;
            if (c == 110) bus.enable = 1'b1;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 1; c <= 6000; c++) begin
            @(negedge clk_in);
            rst = 1'b0;
            n_cmp++;
            if ({bus.tick_16x, bus.tick_1x, bus.cfg_ready, bus.hold_o} !== {m_t16, m_t1, m_ready, m_hold} ||
                bus.cur_div !== DIV_W'(m_div)) begin
                n_bad++;
                $display("FAIL random: cycle %0d t16=%b t1=%b rdy=%b hold=%b div=%0d, want %b %b %b %b %0d",
                         c, bus.tick_16x, bus.tick_1x, bus.cfg_ready, bus.hold_o, bus.cur_div,
                         m_t16, m_t1, m_ready, m_hold, m_div);
            end
            bus.enable    = ($urandom_range(0, 9) != 0);
            bus.cfg_valid = ($urandom_range(0, 19) == 0);
            bus.cfg_div   = DIV_W'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) bus.tx_busy = ~bus.tx_busy;
            if ($urandom_range(0, 7) == 0) bus.rx_busy = ~bus.rx_busy;
            if ($urandom_range(0, 1999) == 0) rst = 1'b1;
        end
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_rate();
        test_reconfig(16'd3, 3, "div3");
        test_reconfig(16'd0, 1, "div0");
        test_drain_busy();
        test_reset_in_drain();
        test_enable_freeze();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
